// File: rtl/sprite_renderer_param_pkg.sv
// rtl/sprite_renderer_param_pkg.sv - shared state encoding and constants for the sprite renderer
// Purpose: FSM state type and scale-field width used by the sprite renderer slice.
// Ports: none (package).
package sprite_renderer_param_pkg;

  localparam int SPR_SCALE_W = 2;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_LOAD   = 3'd1,
    S_LOAD_SETUP  = 3'd2,
    S_LOAD_FETCH  = 3'd3,
    S_WAIT_HSTART = 3'd4,
    S_DRAW        = 3'd5
  } state_t;

endpackage

// File: rtl/sprite_pixel_sel.sv
// rtl/sprite_pixel_sel.sv - combinational mirror/flip pixel picker for one sprite row
// Purpose: maps a drawn column to a source pixel of the buffered ROM row.
// Ports:
//   row_buf  in  SRC_W*BPP  buffered ROM row, pixel i at [i*BPP +: BPP]
//   col      in  COL_W      drawn column, 0..DRAW_W-1
//   hflip    in  1          horizontal flip
//   pix      out BPP        selected pixel value
module sprite_pixel_sel
  import sprite_renderer_param_pkg::*;
#(
  parameter int SRC_W  = 8,
  parameter int BPP    = 1,
  parameter int MIRROR = 1,
  parameter int COL_W  = $clog2((MIRROR != 0) ? 2 * SRC_W : SRC_W)
) (
  input  logic [SRC_W*BPP-1:0] row_buf,
  input  logic [COL_W-1:0]     col,
  input  logic                 hflip,
  output logic [BPP-1:0]       pix
);

  localparam int IDX_W = $clog2(SRC_W);

  logic [IDX_W-1:0] idx_m;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // Right half of a mirrored sprite walks the source row backwards.
    if (MIRROR != 0 && int'(col) >= SRC_W) begin
      idx_m = IDX_W'(2 * SRC_W - 1 - int'(col));
    end else begin
      idx_m = IDX_W'(col);
    end
    idx = hflip ? (IDX_W'(SRC_W - 1) - idx_m) : idx_m;
    pix = row_buf[idx*BPP +: BPP];
  end

endmodule

// File: rtl/sprite_renderer_param.sv
// rtl/sprite_renderer_param.sv - parametrised scanline sprite renderer with flip and scaling
// Purpose: fetches one ROM row per scanline during load, shifts pixels out from hstart.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   vstart, load, hstart  position strobes (top line, fetch window, left edge)
//   hflip, vflip          flips, latched on vstart acceptance
//   hscale, vscale        log2 pixel/line repeat, latched on vstart acceptance
//   rom_addr / rom_bits   registered ROM row address / row data one cycle later
//   gfx, opaque           registered pixel value and non-zero flag
//   in_progress           high whenever not idle
//   done                  one-cycle pulse with the final pixel of the final line
module sprite_renderer_param
  import sprite_renderer_param_pkg::*;
#(
  parameter int SRC_W  = 8,
  parameter int HEIGHT = 16,
  parameter int BPP    = 1,
  parameter int MIRROR = 1,
  localparam int ADDR_W = $clog2(HEIGHT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vstart,
  input  logic                   load,
  input  logic                   hstart,
  input  logic                   hflip,
  input  logic                   vflip,
  input  logic [SPR_SCALE_W-1:0] hscale,
  input  logic [SPR_SCALE_W-1:0] vscale,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [SRC_W*BPP-1:0]   rom_bits,
  output logic [BPP-1:0]         gfx,
  output logic                   opaque,
  output logic                   in_progress,
  output logic                   done
);

  localparam int DRAW_W = (MIRROR != 0) ? 2 * SRC_W : SRC_W;
  localparam int COL_W  = $clog2(DRAW_W);

  state_t                 state;
  logic [COL_W-1:0]       col;
  logic [2:0]             sub;
  logic [ADDR_W-1:0]      row;
  logic [2:0]             rep;
  logic                   hflip_q;
  logic                   vflip_q;
  logic [SPR_SCALE_W-1:0] hscale_q;
  logic [SPR_SCALE_W-1:0] vscale_q;
  logic [SRC_W*BPP-1:0]   row_buf;
  logic [BPP-1:0]         pix;
  logic [2:0]             sub_max;
  logic [2:0]             rep_max;
  logic                   sub_last;
  logic                   col_last;
  logic                   rep_last;
  logic                   row_last;

  sprite_pixel_sel #(
    .SRC_W  (SRC_W),
    .BPP    (BPP),
    .MIRROR (MIRROR),
    .COL_W  (COL_W)
  ) u_pixel_sel (
    .row_buf (row_buf),
    .col     (col),
    .hflip   (hflip_q),
    .pix     (pix)
  );

  // Terminal counts are compared, never relied on as counter overflow.
  always_comb begin
    sub_max  = 3'((4'd1 << hscale_q) - 4'd1);
    rep_max  = 3'((4'd1 << vscale_q) - 4'd1);
    sub_last = (sub == sub_max);
    col_last = (col == COL_W'(DRAW_W - 1));
    rep_last = (rep == rep_max);
    row_last = (row == ADDR_W'(HEIGHT - 1));
  end

  assign in_progress = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      col      <= '0;
      sub      <= '0;
      row      <= '0;
      rep      <= '0;
      hflip_q  <= 1'b0;
      vflip_q  <= 1'b0;
      hscale_q <= '0;
      vscale_q <= '0;
      row_buf  <= '0;
      rom_addr <= '0;
      gfx      <= '0;
      opaque   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          row    <= '0;
          rep    <= '0;
          gfx    <= '0;
          opaque <= 1'b0;
          if (vstart) begin
            hflip_q  <= hflip;
            vflip_q  <= vflip;
            hscale_q <= hscale;
            vscale_q <= vscale;
            state    <= S_WAIT_LOAD;
          end
        end
        S_WAIT_LOAD: begin
          col    <= '0;
          sub    <= '0;
          gfx    <= '0;
          opaque <= 1'b0;
          if (load) state <= S_LOAD_SETUP;
        end
        S_LOAD_SETUP: begin
          rom_addr <= vflip_q ? (ADDR_W'(HEIGHT - 1) - row) : row;
          state    <= S_LOAD_FETCH;
        end
        S_LOAD_FETCH: begin
          row_buf <= rom_bits;
          state   <= S_WAIT_HSTART;
        end
        S_WAIT_HSTART: begin
          gfx    <= '0;
          opaque <= 1'b0;
          if (hstart) state <= S_DRAW;
        end
        S_DRAW: begin
          gfx    <= pix;
          opaque <= |pix;
          if (sub_last) begin
            sub <= '0;
            if (col_last) begin
              col <= '0;
              // Line finished: repeat the same row until vscale repeats are used up.
              if (rep_last) begin
                rep <= '0;
                if (row_last) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                end else begin
                  row   <= row + ADDR_W'(1);
                  state <= S_WAIT_LOAD;
                end
              end else begin
                rep   <= rep + 3'd1;
                state <= S_WAIT_LOAD;
              end
            end else begin
              col <= col + COL_W'(1);
            end
          end else begin
            sub <= sub + 3'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          gfx    <= '0;
          opaque <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_renderer_param.sv
// tb/tb_sprite_renderer_param.sv - scoreboard bench for sprite_renderer_param
module tb_sprite_renderer_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hflip = 1'b0, vflip = 1'b0;
  logic [1:0] hscale = 2'd0, vscale = 2'd0;

  logic       vstart0 = 1'b0, load0 = 1'b0, hstart0 = 1'b0;
  logic [3:0] rom_addr0;
  logic [7:0] rom_bits0;
  logic [0:0] gfx0;
  logic       opaque0, prog0, done0;

  logic       vstart1 = 1'b0, load1 = 1'b0, hstart1 = 1'b0;
  logic [1:0] rom_addr1;
  logic [7:0] rom_bits1;
  logic [1:0] gfx1;
  logic       opaque1, prog1, done1;

  logic [7:0] rom0 [16];
  logic [7:0] rom1 [4];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int    cyc;
    int    d;
    int    gfx;
    bit    dn;
    bit    pg;
    int    addr;
    string tag;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_bits0 = rom0[rom_addr0];
  assign rom_bits1 = rom1[rom_addr1];

  sprite_renderer_param dut0 (
    .clk(clk), .reset(reset), .vstart(vstart0), .load(load0), .hstart(hstart0),
    .hflip(hflip), .vflip(vflip), .hscale(hscale), .vscale(vscale),
    .rom_addr(rom_addr0), .rom_bits(rom_bits0), .gfx(gfx0), .opaque(opaque0),
    .in_progress(prog0), .done(done0)
  );

  sprite_renderer_param #(.SRC_W(4), .HEIGHT(4), .BPP(2), .MIRROR(0)) dut1 (
    .clk(clk), .reset(reset), .vstart(vstart1), .load(load1), .hstart(hstart1),
    .hflip(hflip), .vflip(vflip), .hscale(hscale), .vscale(vscale),
    .rom_addr(rom_addr1), .rom_bits(rom_bits1), .gfx(gfx1), .opaque(opaque1),
    .in_progress(prog1), .done(done1)
  );

  // Monitor: pops every expectation whose cycle has arrived and compares it.
  int a_gfx, a_addr;
  bit a_opq, a_dn, a_pg;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.d == 0) begin
        a_gfx = int'(gfx0); a_opq = opaque0; a_dn = done0; a_pg = prog0; a_addr = int'(rom_addr0);
      end else begin
        a_gfx = int'(gfx1); a_opq = opaque1; a_dn = done1; a_pg = prog1; a_addr = int'(rom_addr1);
      end
      checks++;
      if (e.cyc != cyc || a_gfx != e.gfx || a_opq != (e.gfx != 0) || a_dn != e.dn ||
          a_pg != e.pg || (e.addr >= 0 && a_addr != e.addr)) begin
        errors++;
        $display("FAIL %s dut%0d cyc %0d (due %0d): gfx %0d want %0d, opaque %0d want %0d, done %0d want %0d, in_progress %0d want %0d, rom_addr %0d want %0d",
                 e.tag, e.d, cyc, e.cyc, a_gfx, e.gfx, a_opq, (e.gfx != 0), a_dn, e.dn,
                 a_pg, e.pg, a_addr, e.addr);
      end
    end
  end

  function automatic int exp_px(input logic [7:0] bits, input int col, input bit hf,
                                input int sw, input int bpp, input bit mir);
    int idx;
    logic [7:0] sh;
    idx = col;
    if (mir && col >= sw) idx = 2 * sw - 1 - col;
    if (hf) idx = sw - 1 - idx;
    sh = bits >> (idx * bpp);
    return int'(sh) & ((1 << bpp) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int d, input int g, input bit dn, input bit pg,
                      input int a, input string tag);
    exp_t e;
    e.cyc = c; e.d = d; e.gfx = g; e.dn = dn; e.pg = pg; e.addr = a; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic set_ctl(input int d, input bit v, input bit l, input bit h);
    if (d == 0) begin
      vstart0 = v; load0 = l; hstart0 = h;
    end else begin
      vstart1 = v; load1 = l; hstart1 = h;
    end
  endtask

  // Drives one whole sprite and queues every pixel it should produce.
  task automatic run_sprite(input int d, input bit hf, input bit vf, input int hs, input int vs,
                            input bit vs_with_load, input int abort_line);
    int sw, ht, bpp, dw, n, lines, row, addr, j, k;
    bit mir, last;
    logic [7:0] bits;
    sw = (d == 0) ? 8 : 4;
    ht = (d == 0) ? 16 : 4;
    bpp = (d == 0) ? 1 : 2;
    mir = (d == 0);
    dw = mir ? 2 * sw : sw;
    n = dw << hs;
    lines = ht << vs;
    hflip = hf; vflip = vf; hscale = 2'(hs); vscale = 2'(vs);
    set_ctl(d, 1'b1, vs_with_load, 1'b0);
    tick();
    set_ctl(d, 1'b0, 1'b0, 1'b0);
    // Mode inputs move after acceptance; the latched values must hold.
    hflip = ~hf; vflip = ~vf; hscale = 2'(3 - hs); vscale = 2'(3 - vs);
    for (int L = 0; L < lines; L++) begin
      row = L >> vs;
      addr = vf ? ht - 1 - row : row;
      bits = (d == 0) ? rom0[addr] : rom1[addr];
      last = (L == lines - 1);
      tick();
      j = cyc;
      set_ctl(d, 1'b0, 1'b1, 1'b0);
      push(j + 2, d, 0, 1'b0, 1'b1, addr, "fetch_addr");
      tick();
      set_ctl(d, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      set_ctl(d, 1'b1, 1'b1, 1'b0);
      tick();
      set_ctl(d, 1'b0, 1'b0, 1'b1);
      k = cyc;
      tick();
      set_ctl(d, 1'b0, 1'b0, 1'b0);
      if (L == abort_line) begin
        for (int p = 0; p < 5; p++)
          push(k + 2 + p, d, exp_px(bits, p, hf, sw, bpp, mir), 1'b0, 1'b1, -1, "pixel_pre_reset");
        push(k + 7, d, 0, 1'b0, 1'b0, 0, "reset_mid_draw");
        push(k + 8, d, 0, 1'b0, 1'b0, 0, "reset_idle");
        while (cyc < k + 6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        while (cyc < k + 9) tick();
        return;
      end
      for (int p = 0; p < n; p++)
        push(k + 2 + p, d, exp_px(bits, p >> hs, hf, sw, bpp, mir),
             last && p == n - 1, !(last && p == n - 1), -1, "pixel");
      push(k + 2 + n, d, 0, 1'b0, !last, addr, "post_line");
      while (cyc < k + n + 2) tick();
    end
  endtask

  initial begin
    rom0[0]  = 8'b0000_0001; rom0[1]  = 8'h80; rom0[2]  = 8'h3C; rom0[3]  = 8'hFF;
    rom0[4]  = 8'h00;        rom0[5]  = 8'h5A; rom0[6]  = 8'hA5; rom0[7]  = 8'h18;
    rom0[8]  = 8'h81;        rom0[9]  = 8'h7E; rom0[10] = 8'h0F; rom0[11] = 8'hF0;
    rom0[12] = 8'h24;        rom0[13] = 8'h42; rom0[14] = 8'hC3; rom0[15] = 8'h99;
    rom1[0] = 8'b11_10_01_00; rom1[1] = 8'b00_01_10_11;
    rom1[2] = 8'b01_01_00_10; rom1[3] = 8'b10_00_11_01;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    push(cyc, 0, 0, 1'b0, 1'b0, 0, "reset_state");
    push(cyc, 1, 0, 1'b0, 1'b0, 0, "reset_state");
    tick();

    run_sprite(0, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    run_sprite(0, 1'b1, 1'b1, 0, 0, 1'b0, -1);
    run_sprite(0, 1'b0, 1'b0, 2, 1, 1'b0, -1);
    run_sprite(0, 1'b0, 1'b0, 0, 0, 1'b0, 3);
    run_sprite(0, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    run_sprite(1, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    run_sprite(1, 1'b1, 1'b1, 1, 0, 1'b0, -1);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
